// File: rtl/pll_ctrl.sv
// pll_ctrl -- acquisition sequencer for the iCE40 PLL (12 MHz ref -> 127.5 MHz core).
//
// Lives entirely in the 12 MHz reference domain. Holds the PLL in reset for
// RST_CYCLES, waits up to LOCK_TIMEOUT for LOCK, then requires SETTLE_CYCLES of
// continuous lock before raising 'ready' for the fast-domain reset generator.
// Timed-out attempts are retried; after MAX_RETRIES failures the sequencer parks
// in FAIL until 'restart' or 'rst_n'. Losing lock while LOCKED re-runs acquisition.
//
// Ports:
//   clk_in     in   12 MHz reference clock (only clock)
//   rst_n      in   asynchronous active-low reset
//   pll_lock   in   PLL LOCK, asynchronous (synchronised here)
//   restart    in   single-cycle synchronous re-acquire request
//   pll_resetb out  PLL RESETB (0 holds PLL in reset)
//   ready      out  PLL locked and settled
//   fail       out  acquisition abandoned
//   state      out  debug state: RESET=0 WAIT_LOCK=1 SETTLE=2 LOCKED=3 FAIL=4
//   retry_cnt  out  cumulative timed-out attempts (saturating)
//   loss_cnt   out  cumulative lock losses from LOCKED (saturating)

module pll_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1200,
    parameter int SETTLE_CYCLES = 120,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             restart,
    output logic             pll_resetb,
    output logic             ready,
    output logic             fail,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    // One shared cycle counter sized for the longest timed interval.
    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int AW      = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t          cur_state, next_state;
    logic [CW-1:0]   cyc_cnt, cyc_nxt;
    logic [AW-1:0]   attempt, attempt_nxt, attempt_inc;
    logic            lock_meta, lock_s;
    logic            timeout, lost;
    logic            resetb_nxt, ready_nxt, fail_nxt;
    logic [CNT_W-1:0] retry_nxt, loss_nxt;

    assign state       = cur_state;
    assign attempt_inc = attempt + AW'(1);

    // State register: synchroniser, FSM state, counters and all registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            cur_state  <= ST_RESET;
            cyc_cnt    <= '0;
            attempt    <= '0;
            pll_resetb <= 1'b0;
            ready      <= 1'b0;
            fail       <= 1'b0;
            retry_cnt  <= '0;
            loss_cnt   <= '0;
        end else begin
            lock_meta  <= pll_lock;
            lock_s     <= lock_meta;
            cur_state  <= next_state;
            cyc_cnt    <= cyc_nxt;
            attempt    <= attempt_nxt;
            pll_resetb <= resetb_nxt;
            ready      <= ready_nxt;
            fail       <= fail_nxt;
            retry_cnt  <= retry_nxt;
            loss_cnt   <= loss_nxt;
        end
    end

    // Next-state logic. Lock is checked before the timeout so a lock arriving on
    // the timeout cycle wins. restart overrides everything, including a loss.
    always_comb begin
        next_state = cur_state;
        timeout    = 1'b0;
        lost       = 1'b0;
        case (cur_state)
            ST_RESET: begin
                if (cyc_cnt == CW'(RST_CYCLES - 1))
                    next_state = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = ST_SETTLE;
                end else if (cyc_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    next_state = (attempt_inc == AW'(MAX_RETRIES)) ? ST_FAIL : ST_RESET;
                end
            end
            ST_SETTLE: begin
                if (!lock_s)
                    next_state = ST_WAIT_LOCK;
                else if (cyc_cnt == CW'(SETTLE_CYCLES - 1))
                    next_state = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (!lock_s) begin
                    lost       = 1'b1;
                    next_state = ST_RESET;
                end
            end
            ST_FAIL: begin
                next_state = ST_FAIL;
            end
            default: begin
                next_state = ST_RESET;
            end
        endcase
        if (restart) begin
            next_state = ST_RESET;
            timeout    = 1'b0;
            lost       = 1'b0;
        end

        // Counter restarts on every transition; it idles at 0 in untimed states.
        if (restart || next_state != cur_state ||
            cur_state == ST_LOCKED || cur_state == ST_FAIL)
            cyc_nxt = '0;
        else
            cyc_nxt = cyc_cnt + CW'(1);

        // Attempts are counted per acquisition and forgotten once lock is reached.
        if (restart)
            attempt_nxt = '0;
        else if (timeout)
            attempt_nxt = attempt_inc;
        else if (next_state == ST_LOCKED && cur_state != ST_LOCKED)
            attempt_nxt = '0;
        else
            attempt_nxt = attempt;
    end

    // Output logic: next values of the registered outputs, decoded from next_state.
    always_comb begin
        resetb_nxt = (next_state == ST_WAIT_LOCK) || (next_state == ST_SETTLE) ||
                     (next_state == ST_LOCKED);
        ready_nxt  = (next_state == ST_LOCKED);
        fail_nxt   = (next_state == ST_FAIL);
        retry_nxt  = retry_cnt;
        loss_nxt   = loss_cnt;
        if (timeout && retry_cnt != {CNT_W{1'b1}})
            retry_nxt = retry_cnt + CNT_W'(1);
        if (lost && loss_cnt != {CNT_W{1'b1}})
            loss_nxt = loss_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl -- directed bench for pll_ctrl with short timing parameters
// (RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_pll_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int SETTLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 3;
    localparam int CNT_W         = 8;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             pll_lock;
    logic             restart;
    logic             pll_resetb;
    logic             ready;
    logic             fail;
    logic [2:0]       state;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    int vectors    = 0;
    int miscompares = 0;

    pll_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .restart   (restart),
        .pll_resetb(pll_resetb),
        .ready     (ready),
        .fail      (fail),
        .state     (state),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Drive inputs, then advance n rising edges, settling 1 unit past the last.
    task automatic applyStimulus(input logic lock_v, input logic restart_v, input int n);
        pll_lock = lock_v;
        restart  = restart_v;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        restart  = 1'b0;
        #2;
        checkOutput("rst_state",  32'(state),      0);
        checkOutput("rst_resetb", 32'(pll_resetb), 0);
        checkOutput("rst_ready",  32'(ready),      0);
        checkOutput("rst_fail",   32'(fail),       0);
        checkOutput("rst_retry",  32'(retry_cnt),  0);
        checkOutput("rst_loss",   32'(loss_cnt),   0);
        applyStimulus(1'b0, 1'b0, 2);
        rst_n = 1'b1;

        // Power-up: RESETB held low for 4 cycles, then WAIT_LOCK.
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("pwr_resetb_low", 32'(pll_resetb), 0);
        checkOutput("pwr_state_rst",  32'(state),      0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("pwr_resetb_high", 32'(pll_resetb), 1);
        checkOutput("pwr_state_wait",  32'(state),      1);

        // Lock 5 cycles into WAIT_LOCK; ready 10 edges after first sample.
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("acq_wait", 32'(state), 1);
        applyStimulus(1'b1, 1'b0, 9);
        checkOutput("acq_settle",  32'(state), 2);
        checkOutput("acq_ready8",  32'(ready), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("acq_ready9",  32'(ready), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("acq_ready10", 32'(ready), 1);
        checkOutput("acq_locked",  32'(state), 3);
        checkOutput("acq_retry",   32'(retry_cnt), 0);
        checkOutput("acq_loss",    32'(loss_cnt),  0);

        // One-cycle lock drop while LOCKED.
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("loss_ready1", 32'(ready), 1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("loss_ready2", 32'(ready), 1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("loss_ready_drop", 32'(ready),      0);
        checkOutput("loss_cnt1",       32'(loss_cnt),   1);
        checkOutput("loss_state_rst",  32'(state),      0);
        checkOutput("loss_resetb",     32'(pll_resetb), 0);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("loss_rst_hold", 32'(state), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("loss_wait",     32'(state), 1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("loss_settle",   32'(state), 2);
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("loss_ready_early", 32'(ready), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("loss_relock",   32'(ready), 1);
        checkOutput("loss_relock_st", 32'(state), 3);

        // Restart from LOCKED: no loss counted.
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("rs_lk_state", 32'(state),    0);
        checkOutput("rs_lk_ready", 32'(ready),    0);
        checkOutput("rs_lk_loss",  32'(loss_cnt), 1);

        // Lock glitch in SETTLE at counter=5: back to WAIT_LOCK, full settle again.
        applyStimulus(1'b1, 1'b0, 4);
        checkOutput("gl_wait",   32'(state), 1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("gl_settle", 32'(state), 2);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("gl_settle_c5", 32'(state), 2);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("gl_back_wait", 32'(state),     1);
        checkOutput("gl_retry",     32'(retry_cnt), 0);
        checkOutput("gl_loss",      32'(loss_cnt),  1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("gl_resettle",  32'(state), 2);
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("gl_ready_early", 32'(ready), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("gl_ready",     32'(ready), 1);

        // Lock absent: three timeouts then FAIL.
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("to_restart_state", 32'(state),    0);
        checkOutput("to_restart_loss",  32'(loss_cnt), 1);
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("to_rst0",   32'(state), 0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("to_wait0",  32'(state),      1);
        checkOutput("to_rb0",    32'(pll_resetb), 1);
        applyStimulus(1'b0, 1'b0, 19);
        checkOutput("to_pre1_state", 32'(state),     1);
        checkOutput("to_pre1_retry", 32'(retry_cnt), 0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("to1_state",  32'(state),      0);
        checkOutput("to1_retry",  32'(retry_cnt),  1);
        checkOutput("to1_resetb", 32'(pll_resetb), 0);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("to1_wait",   32'(state), 1);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("to2_state",  32'(state),     0);
        checkOutput("to2_retry",  32'(retry_cnt), 2);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("to2_wait",   32'(state), 1);
        applyStimulus(1'b0, 1'b0, 19);
        checkOutput("to3_pre_fail",  32'(fail),  0);
        checkOutput("to3_pre_state", 32'(state), 1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("fail_flag",   32'(fail),       1);
        checkOutput("fail_state",  32'(state),      4);
        checkOutput("fail_resetb", 32'(pll_resetb), 0);
        checkOutput("fail_retry",  32'(retry_cnt),  3);
        checkOutput("fail_ready",  32'(ready),      0);
        applyStimulus(1'b0, 1'b0, 5);
        checkOutput("fail_stay", 32'(state), 4);

        // Restart from FAIL, then acquire.
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("rs_fail_flag",  32'(fail),      0);
        checkOutput("rs_fail_state", 32'(state),     0);
        checkOutput("rs_fail_retry", 32'(retry_cnt), 3);
        applyStimulus(1'b1, 1'b0, 12);
        checkOutput("rs_settle",      32'(state), 2);
        checkOutput("rs_ready_early", 32'(ready), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("rs_ready",  32'(ready),     1);
        checkOutput("rs_locked", 32'(state),     3);
        checkOutput("rs_retry",  32'(retry_cnt), 3);
        checkOutput("rs_fail0",  32'(fail),      0);

        // Asynchronous reset while LOCKED, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_ready",  32'(ready),      0);
        checkOutput("ar_resetb", 32'(pll_resetb), 0);
        checkOutput("ar_state",  32'(state),      0);
        checkOutput("ar_retry",  32'(retry_cnt),  0);
        checkOutput("ar_loss",   32'(loss_cnt),   0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
